// File: rtl/risc_pkg.sv
// Shared constants for the RISC instruction sequencer.
//   PHASE_W / OP_W : widths of the phase counter and the opcode field
//   HLT..JMP       : opcode encodings (top 3 bits of the instruction)
//   INST_ADDR..STORE : names of the eight sequencer phases
package risc_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] HLT = 3'd0;
    localparam logic [OP_W-1:0] SKZ = 3'd1;
    localparam logic [OP_W-1:0] ADD = 3'd2;
    localparam logic [OP_W-1:0] AND = 3'd3;
    localparam logic [OP_W-1:0] XOR = 3'd4;
    localparam logic [OP_W-1:0] LDA = 3'd5;
    localparam logic [OP_W-1:0] STO = 3'd6;
    localparam logic [OP_W-1:0] JMP = 3'd7;

    localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] STORE      = 3'd7;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [OP_W-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// Free-running modulo-8 phase counter for the instruction sequencer.
//   clk   : system clock
//   rst   : asynchronous active-high reset, forces phase to INST_ADDR
//   en    : count enable; counter holds its value while low
//   phase : current phase
module risc_phase_counter
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q, phase_d;

    // Natural wrap of the 3-bit add gives 7 -> 0 with no extra cycle.
    always_comb begin
        phase_d = phase_q;
        if (en) begin
            phase_d = phase_q + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/risc_controller.sv
// 8-phase instruction sequencer: phases 0-3 fetch, 4-7 execute.
//   clk, rst : clock and asynchronous active-high reset
//   opcode   : opcode from the instruction register
//   zero     : accumulator-is-zero flag
//   sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e : datapath strobes,
//              decoded combinationally from (phase, opcode, zero)
//   halt     : sticky halt, set at the end of OP_ADDR of a HLT instruction
//   phase    : current phase (debug)
module risc_controller
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    logic halt_q, halt_d;
    logic aluop;

    // Counter stops while halted, leaving phase parked at OP_FETCH.
    risc_phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (~halt_q),
        .phase (phase)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Next-state: halt latches on the edge that closes OP_ADDR of a HLT.
    always_comb begin
        halt_d = halt_q;
        if ((phase == OP_ADDR) && (opcode == HLT)) begin
            halt_d = 1'b1;
        end
    end

    assign aluop = is_aluop(opcode);
    assign halt  = halt_q;

    // Output decode
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        unique case (phase)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
            end
            OP_FETCH: begin
                rd = aluop;
            end
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                inc_pc = (opcode == JMP);
                ld_pc  = (opcode == JMP);
                wr     = (opcode == STO);
                data_e = (opcode == STO);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
`timescale 1ns/1ps
module tb_risc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    risc_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    always #50 clk = ~clk;

    typedef struct packed {
        logic [2:0] phase;
        logic       halt;
        logic [7:0] strb;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Bench-side model of the sequencer state.
    logic [2:0] m_phase = 3'd0;
    logic       m_halt  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode, bit order {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}.
    function automatic logic [7:0] ref_strb(input logic [2:0] ph, input logic [2:0] op,
                                            input logic z);
        logic alu;
        logic [7:0] s;
        alu = (op >= 3'd2) && (op <= 3'd5);
        s = 8'h00;
        case (ph)
            3'd0: s = 8'b1000_0000;
            3'd1: s = 8'b1100_0000;
            3'd2: s = 8'b1110_0000;
            3'd3: s = 8'b1110_0000;
            3'd4: s = 8'b0001_0000;
            3'd5: s = {1'b0, alu, 6'b0};
            3'd6: s = {1'b0, alu, 1'b0, (op == 3'd1) && z, op == 3'd7, 2'b0, op == 3'd6};
            default: s = {1'b0, alu, 1'b0, op == 3'd7, op == 3'd7, alu, op == 3'd6, op == 3'd6};
        endcase
        return s;
    endfunction

    task automatic drive(input logic [2:0] op, input logic z);
        exp_t e;
        opcode = op;
        zero   = z;
        e.phase = m_phase;
        e.halt  = m_halt;
        e.strb  = ref_strb(m_phase, op, z);
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("phase", phase, e.phase);
            check("halt", halt, e.halt);
            check("strobes", {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}, e.strb);
            check("no_x", $isunknown({rd, wr, ld_ir}), 0);
            if (phase < 3'd6) check("inv_wr_ldpc", {wr, ld_pc}, 2'b00);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && !m_halt) begin
            if (m_phase == 3'd4 && opcode == 3'd0) m_halt = 1'b1;
            m_phase = m_phase + 3'd1;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic [2:0] op, input logic z);
        drive(op, z);
        sample();
        tick();
    endtask

    task automatic async_reset(input logic [2:0] op);
        rst = 1'b1;
        m_phase = 3'd0;
        m_halt  = 1'b0;
        drive(op, 1'b0);
        sample();
        tick();
        drive(op, 1'b0);
        sample();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        drive(3'd2, 1'b0);
        sample();
        rst = 1'b0;

        // HLT from clean reset: one clock to phase 1, three more to phase 4, then halt.
        opcode = 3'd0;
        tick();
        check("hlt_p1", phase, 3'd1);
        repeat (3) tick();
        check("hlt_p4", phase, 3'd4);
        check("hlt_p4_halt", halt, 1'b0);
        tick();
        check("hlt_set", halt, 1'b1);
        check("hlt_p5", phase, 3'd5);
        repeat (10) cyc(3'd0, 1'b0);
        check("hlt_frozen", phase, 3'd5);

        // Reset out of halt, then again in the middle of an ADD at phase 5.
        @(negedge clk);
        async_reset(3'd2);
        repeat (5) cyc(3'd2, 1'b0);
        check("pre_rst_p5", phase, 3'd5);
        async_reset(3'd2);

        // JMP with wrap, SKZ both ways, ALU ops, STO.
        repeat (9) cyc(3'd7, 1'b0);
        check("jmp_wrap", phase, 3'd1);
        repeat (7) cyc(3'd2, 1'b0);
        repeat (8) cyc(3'd1, 1'b1);
        repeat (8) cyc(3'd1, 1'b0);
        for (int op = 2; op <= 6; op++) begin
            repeat (8) cyc(3'(op), 1'b0);
        end

        // Exhaustive decode: every opcode/zero combination in every phase.
        for (int p = 0; p < 8; p++) begin
            for (int op = 0; op < 8; op++) begin
                for (int z = 0; z < 2; z++) begin
                    drive(3'(op), 1'(z));
                    sample();
                end
            end
            opcode = 3'd2;
            tick();
        end

        // Finish on a HLT after a non-halting instruction.
        repeat (8) cyc(3'd5, 1'b1);
        repeat (5) cyc(3'd0, 1'b0);
        repeat (3) cyc(3'd0, 1'b1);
        check("final_halt", halt, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- 8-phase instruction sequencer for the Risc_top CPU. It sits between the instruction register, which supplies the opcode, and the datapath: PC, address mux, memory, accumulator and data driver.
- Every instruction takes exactly 8 clocks: fetch in phases 0-3, execute in phases 4-7.
- The block produces all datapath strobes and the sticky halt seen at the top level.

Parameters:
- PHASE_W, 3, width of the phase counter (8 phases).
- OP_W, 3, opcode width (top 3 bits of the 8-bit instruction).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  OP_W  opcode from the instruction register (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7).
- zero  in  1  accumulator == 0 flag from the ALU.
- sel  out  1  address mux select: 1 = PC, 0 = IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  load instruction register.
- inc_pc  out  1  increment PC.
- ld_pc  out  1  load PC from IR operand.
- ld_ac  out  1  load accumulator from ALU.
- wr  out  1  memory write strobe.
- data_e  out  1  drive accumulator onto data bus.
- halt  out  1  sticky halt flag.
- phase  out  PHASE_W  current phase, for debug and bench.

Behaviour:
- One clock domain; one asynchronous active-high reset.
- Reset (asserted at any time, including mid-instruction):
  - phase=0 (INST_ADDR), halt=0 immediately.
  - Outputs then show the phase-0 decode: sel=1, all others 0.
- Phase counter:
  - Increments by 1 on each rising edge when rst=0 and halt=0.
  - Wraps 7 -> 0 (modulo 8, no extra cycle).
  - Freezes while halt=1.
- Phase names: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Strobe decode is combinational from (phase, opcode, zero). Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phase 2: sel=1, rd=1, ld_ir=1.
  - Phase 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: inc_pc=1.
  - Phase 5: rd=ALUOP.
  - Phase 6: rd=ALUOP; inc_pc=(SKZ and zero); ld_pc=JMP; data_e=STO.
  - Phase 7: rd=ALUOP; ld_ac=ALUOP; inc_pc=JMP; ld_pc=JMP; wr=STO; data_e=STO.
  - Any output not listed for a phase is 0.
- Halt is registered, not decoded:
  - Set on the rising edge that ends phase 4 when opcode==HLT.
  - Stays 1 until rst.
  - After a HLT fetch, halt is visible 5 clocks after the phase-0 edge of that instruction.
  - While halted, phase stays at 5. Strobes decode phase 5 with opcode HLT, so all are 0.
- An opcode change outside phases 2-3 is a datapath error. The controller does not check for it and simply decodes the current input.
- wr and ld_pc are never asserted in phases 0-5; the bench checks this invariant.
- Clean-reset-to-halt latency, with one clock of rst=0 after release:
  - HLT at address 0: halt=0 after 3 further clocks, halt=1 after 4.
  - Each preceding non-halting instruction adds exactly 8 clocks.

Decomposition:
- Package risc_pkg holds:
  - opcode constants HLT..JMP;
  - phase constants INST_ADDR..STORE;
  - OP_W and PHASE_W.
- Sub-module risc_phase_counter: 3-bit counter with async active-high rst and an enable (= ~halt), output phase.
- The controller instantiates risc_phase_counter. It contains the decode logic and the halt register.

Test Plan:
- Reset mid-run: rst pulsed at phase 5 -> phase=0, halt=0, sel=1 and all other strobes 0, with no clock edge needed.
- HLT sequence: opcode=0 held, one clock after reset release -> phase=1; after 3 more clocks phase=4, halt=0; after 1 more clock halt=1, phase=5; 10 further clocks -> phase still 5, halt still 1.
- JMP: opcode=7 -> ld_pc=1 in phases 6 and 7, inc_pc=1 in phases 4 and 7, wr=0 throughout; phase wraps 7->0.
- SKZ: opcode=1, zero=1 -> inc_pc=1 in phase 6. Repeat with zero=0 -> inc_pc=0 in phase 6; inc_pc=1 only in phase 4.
- ALU ops: opcode in {2,3,4,5} -> rd=1 in phases 5-7, ld_ac=1 only in phase 7. STO (6) -> data_e=1 in phases 6-7, wr=1 only in phase 7, ld_ac=0.
- Exhaustive sweep: all 8 opcodes x 8 phases x zero 0/1 compared against a reference decode model; assert rd, wr and ld_ir are never X after reset.
